// File: rtl/tx_fifo_uart.sv
// tx_fifo_uart
// UART transmitter with a built-in transmit FIFO. Characters queued with
// single-cycle strobes are sent back-to-back, LSB first, framed as
// start, data, [parity], stop.
//
// Optional feature: define TX_PARITY_EN to add a parity bit after the data
// bits. PARITY_ODD then selects odd (1) or even (0) parity. Without the
// macro there is no parity state and PARITY_ODD has no effect.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous active-high reset
//   din      in   character to enqueue, sampled when send=1
//   send     in   single-cycle enqueue strobe
//   full     out  FIFO holds FIFO_DEPTH entries
//   empty    out  FIFO holds no entries
//   busy     out  a frame is on the line
//   sent     out  pulse in the last cycle of each frame's final stop bit
//   overflow out  sticky: a send arrived while full (cleared by reset)
//   tx_out   out  registered serial line, idle high
//
// State  | meaning
// IDLE   | line high, waiting for a queued character
// START  | start bit (low)
// DATA   | data bits, LSB first
// PARITY | parity bit (TX_PARITY_EN only)
// STOP   | STOP_BITS stop bits (high)
module tx_fifo_uart #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200,
    parameter int DATA_BITS     = 8,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 4,
    parameter int PARITY_ODD    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 send,
    output logic                 full,
    output logic                 empty,
    output logic                 busy,
    output logic                 sent,
    output logic                 overflow,
    output logic                 tx_out
);

    localparam int BAUD_DIV = CLK_FREQUENCY / BAUD_RATE;
    localparam int BAUD_W   = $clog2(BAUD_DIV);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [2:0]        DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // ---------------- FIFO ----------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 overflow_q;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    // full is the registered view from before the edge, so a push into a
    // full FIFO is dropped even when a pop frees a slot in the same cycle.
    assign push  = send & ~full;
    assign head  = mem_q[rd_ptr_q];
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (send && full) overflow_q <= 1'b1;
        end
    end

    // ---------------- transmitter FSM ----------------
    state_t               state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 baud_end;
`ifdef TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign baud_end = (baud_q == BAUD_LAST);
    assign busy     = (state_q != S_IDLE);
    assign tx_out   = tx_q;

    always_comb begin
        state_d = state_q;
        // State changes only happen on baud_end, so the wrap to zero is
        // also the clear on state entry.
        baud_d  = baud_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        sent    = 1'b0;
`ifdef TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        sent = 1'b1;
                        // Chain straight into the next start bit when more
                        // characters are waiting.
                        if (!empty) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            shift_d = head;
`ifdef TX_PARITY_EN
            par_d   = (^head) ^ 1'(PARITY_ODD);
`endif
        end

        // tx is registered from the next state so it lines up with state_q.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
`ifdef TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_tx_fifo_uart.sv
// Directed bench for tx_fifo_uart with BAUD_DIV=10. Two instances: the
// default 8N1 build and a 5-data-bit, 2-stop-bit variant (even parity when
// parity is compiled in). Outputs are sampled on the falling edge.
module tb_tx_fifo_uart;

`ifdef TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB8 = 10 + P;
    localparam int NB5 = 8 + P;

    logic       clk;
    logic       reset;
    logic [7:0] din8;
    logic       send8;
    logic       full8, empty8, busy8, sent8, ovf8, tx8;
    logic [4:0] din5;
    logic       send5;
    logic       full5, empty5, busy5, sent5, ovf5, tx5;

    int n_cmp = 0;
    int n_err = 0;

    tx_fifo_uart #(
        .CLK_FREQUENCY(1000), .BAUD_RATE(100), .DATA_BITS(8),
        .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(1)
    ) u_dut (
        .clk(clk), .reset(reset), .din(din8), .send(send8),
        .full(full8), .empty(empty8), .busy(busy8), .sent(sent8),
        .overflow(ovf8), .tx_out(tx8)
    );

    tx_fifo_uart #(
        .CLK_FREQUENCY(1000), .BAUD_RATE(100), .DATA_BITS(5),
        .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(0)
    ) u_dut5 (
        .clk(clk), .reset(reset), .din(din5), .send(send5),
        .full(full5), .empty(empty5), .busy(busy5), .sent(sent5),
        .overflow(ovf5), .tx_out(tx5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Line bits LSB first: start, data, [parity], stop(s).
    function automatic logic [11:0] fr8(input logic [7:0] d);
`ifdef TX_PARITY_EN
        return {2'b01, (^d) ^ 1'b1, d, 1'b0};
`else
        return {2'b00, 1'b1, d, 1'b0};
`endif
    endfunction

    function automatic logic [11:0] fr5(input logic [4:0] d);
`ifdef TX_PARITY_EN
        return {3'b000, 2'b11, ^d, d, 1'b0};
`else
        return {4'b0000, 2'b11, d, 1'b0};
`endif
    endfunction

    // Entered on the falling edge of frame cycle c0 (cycle 0 = first start
    // cycle). Checks the first and last cycle of every bit slot and the
    // position of the sent pulse; leaves on the cycle after the last stop.
    task automatic check_frame(input int which, input logic [11:0] exp,
                               input int nbits, input int c0, input string tag);
        for (int c = c0; c < nbits * 10; c++) begin
            logic txv, sv, bv;
            txv = (which != 0) ? tx5 : tx8;
            sv  = (which != 0) ? sent5 : sent8;
            bv  = (which != 0) ? busy5 : busy8;
            if (c == c0) check({tag, " busy"}, bv, 1'b1);
            if ((c % 10 == 0) || (c % 10 == 9))
                check($sformatf("%s bit%0d c%0d", tag, c / 10, c), txv, exp[c / 10]);
            if (c == nbits * 10 - 2) check({tag, " sent early"}, sv, 1'b0);
            if (c == nbits * 10 - 1) check({tag, " sent"}, sv, 1'b1);
            @(negedge clk);
        end
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        din8  = '0;
        send8 = 1'b0;
        din5  = '0;
        send5 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst tx", tx8, 1'b1);
        check("rst full", full8, 1'b0);
        check("rst empty", empty8, 1'b1);
        check("rst busy", busy8, 1'b0);
        check("rst sent", sent8, 1'b0);
        check("rst ovf", ovf8, 1'b0);
        check("rst5 tx", tx5, 1'b1);
        check("rst5 empty", empty5, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("post rst tx", tx8, 1'b1);
        check("post rst busy", busy8, 1'b0);

        // Single frame 0x41: latency then frame
        din8 = 8'h41; send8 = 1'b1;
        @(negedge clk);
        send8 = 1'b0;
        check("lat empty", empty8, 1'b0);
        check("lat tx", tx8, 1'b1);
        check("lat busy", busy8, 1'b0);
        @(negedge clk);
        check("pop empty", empty8, 1'b1);
        check_frame(0, fr8(8'h41), NB8, 0, "f41");
        check("f41 idle busy", busy8, 1'b0);
        check("f41 idle tx", tx8, 1'b1);
        repeat (5) @(negedge clk);

        // Back-to-back: first pop overlaps the second push, so 3 remain queued
        din8 = 8'h55; send8 = 1'b1;
        @(negedge clk);
        din8 = 8'hAA;
        @(negedge clk);
        din8 = 8'h0F;
        @(negedge clk);
        din8 = 8'hF0;
        @(negedge clk);
        send8 = 1'b0;
        check("b2b full", full8, 1'b0);
        check("b2b empty", empty8, 1'b0);
        check_frame(0, fr8(8'h55), NB8, 2, "f55");
        check_frame(0, fr8(8'hAA), NB8, 0, "fAA");
        check("b2b empty3", empty8, 1'b0);
        check_frame(0, fr8(8'h0F), NB8, 0, "f0F");
        check("b2b empty4", empty8, 1'b1);
        check_frame(0, fr8(8'hF0), NB8, 0, "fF0");
        check("b2b idle", busy8, 1'b0);
        repeat (5) @(negedge clk);

        // Overflow: fill while 0x12 is on the line, then push 0x99 while full
        din8 = 8'h12; send8 = 1'b1;
        @(negedge clk);
        din8 = 8'h21;
        @(negedge clk);
        din8 = 8'h32;
        @(negedge clk);
        din8 = 8'h43;
        @(negedge clk);
        din8 = 8'h54;
        @(negedge clk);
        check("ovf full", full8, 1'b1);
        check("ovf pre", ovf8, 1'b0);
        din8 = 8'h99;
        @(negedge clk);
        send8 = 1'b0;
        check("ovf set", ovf8, 1'b1);
        check("ovf still full", full8, 1'b1);
        check_frame(0, fr8(8'h12), NB8, 4, "f12");
        check_frame(0, fr8(8'h21), NB8, 0, "f21");
        check_frame(0, fr8(8'h32), NB8, 0, "f32");
        check_frame(0, fr8(8'h43), NB8, 0, "f43");
        check_frame(0, fr8(8'h54), NB8, 0, "f54");
        check("ovf idle busy", busy8, 1'b0);
        check("ovf idle empty", empty8, 1'b1);
        repeat (30) @(negedge clk);
        check("ovf no 99 busy", busy8, 1'b0);
        check("ovf no 99 tx", tx8, 1'b1);
        check("ovf sticky", ovf8, 1'b1);

        // Reset mid-frame: during data bit 3 of 0xC3 with two entries queued
        din8 = 8'hC3; send8 = 1'b1;
        @(negedge clk);
        din8 = 8'h11;
        @(negedge clk);
        din8 = 8'h22;
        @(negedge clk);
        send8 = 1'b0;
        repeat (44) @(negedge clk);
        check("mid bit3", tx8, 1'b0);
        check("mid busy", busy8, 1'b1);
        check("mid queued", empty8, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mrst tx", tx8, 1'b1);
        check("mrst busy", busy8, 1'b0);
        check("mrst empty", empty8, 1'b1);
        check("mrst ovf", ovf8, 1'b0);
        repeat (5) @(negedge clk);
        check("mrst quiet busy", busy8, 1'b0);
        repeat (150) @(negedge clk);
        check("mrst late busy", busy8, 1'b0);
        check("mrst late tx", tx8, 1'b1);

`ifdef TX_PARITY_EN
        // Odd parity: 0x03 has two ones, parity slot 9 must be 1
        din8 = 8'h03; send8 = 1'b1;
        @(negedge clk);
        send8 = 1'b0;
        @(negedge clk);
        check_frame(0, {2'b01, 1'b1, 8'h03, 1'b0}, NB8, 0, "f03");
        repeat (5) @(negedge clk);
`endif

        // 5 data bits, 2 stop bits: 0x15
        din5 = 5'h15; send5 = 1'b1;
        @(negedge clk);
        send5 = 1'b0;
        check("w5 lat empty", empty5, 1'b0);
        @(negedge clk);
        check_frame(1, fr5(5'h15), NB5, 0, "f15");
        check("w5 idle busy", busy5, 1'b0);
        check("w5 idle tx", tx5, 1'b1);
        check("w5 idle empty", empty5, 1'b1);
        check("w8 untouched", busy8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
